// File: rtl/mem_if_pkg.sv
// Types and constants shared by the rd/wr request-ack memory interface blocks
// (SDRAM controller and its block-RAM stand-in).
package mem_if_pkg;

   localparam int unsigned LEN_W      = 4;
   localparam int unsigned DEF_AWIDTH = 20;
   localparam int unsigned DEF_DWIDTH = 16;

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StWack,
      StRburst,
      StStall
   } state_e;

   // Bits needed to hold a down-counter loaded with v (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned v);
      return (v < 2) ? 1 : $clog2(v + 1);
   endfunction

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous RAM, one-cycle read latency. Contents are never reset;
// only the read register is cleared so the data output starts at zero.
module bram_sp #(
   parameter int unsigned DWIDTH     = 16,
   parameter int unsigned DEPTH_BITS = 10
) (
   input  logic                  clk,
   input  logic                  sreset,
   input  logic                  we,
   input  logic                  re,
   input  logic [DEPTH_BITS-1:0] addr,
   input  logic [DWIDTH-1:0]     wdata,
   output logic [DWIDTH-1:0]     rdata
);

   logic [DWIDTH-1:0] mem [2**DEPTH_BITS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Read register only updates on a read, so rdata holds between beats.
   always_ff @(posedge clk) begin
      if (sreset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/bram_responder.sv
// Block-RAM backed responder for the rd/wr request-ack memory interface, with
// emulated power-up delay and periodic refresh stalls.
module bram_responder
   import mem_if_pkg::*;
#(
   parameter int unsigned AWIDTH     = DEF_AWIDTH,
   parameter int unsigned DWIDTH     = DEF_DWIDTH,
   parameter int unsigned DEPTH_BITS = 10,
   parameter int unsigned T_PWR_UP   = 3,
   parameter int unsigned T_RI       = 32,
   parameter int unsigned T_RFC      = 4
) (
   input  logic              clk,
   input  logic              sreset,
   input  logic [AWIDTH-1:0] rd_addr,
   input  logic [LEN_W-1:0]  rd_len,
   input  logic              rd_req,
   output logic              rd_ack,
   output logic [DWIDTH-1:0] rd_data,
   output logic              rd_rdy,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic [LEN_W-1:0]  wr_len,
   input  logic              wr_req,
   output logic              wr_ack
);

   localparam int unsigned IW = cnt_width(T_PWR_UP);
   localparam int unsigned RW = cnt_width(T_RI);
   localparam int unsigned FW = cnt_width(T_RFC);

   state_e            state_q, state_d;
   logic [IW-1:0]     init_q, init_d;
   logic [RW-1:0]     ri_q, ri_d;
   logic [FW-1:0]     rfc_q, rfc_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic              pend_q, pend_d;
   logic              last_wr_q, last_wr_d;
   logic              rd_ack_d, wr_ack_d;
   logic              pend_set, pend_clr;
   logic              issue, ram_we;
   logic              unused_wr_len;

   assign unused_wr_len = ^wr_len;

   always_comb begin
      state_d   = state_q;
      init_d    = init_q;
      ri_d      = ri_q;
      rfc_d     = rfc_q;
      beat_d    = beat_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      last_wr_d = last_wr_q;
      rd_ack_d  = 1'b0;
      wr_ack_d  = 1'b0;
      pend_set  = 1'b0;
      pend_clr  = 1'b0;
      issue     = 1'b0;
      ram_we    = 1'b0;

      if ((T_RI != 0) && (state_q != StInit)) begin
         if (ri_q == '0) begin
            ri_d     = RW'(T_RI);
            pend_set = 1'b1;
         end else begin
            ri_d = ri_q - RW'(1);
         end
      end

      case (state_q)
         StInit: begin
            if (init_q <= IW'(1)) begin
               state_d = StIdle;
            end else begin
               init_d = init_q - IW'(1);
            end
         end
         StIdle: begin
            if (pend_q) begin
               state_d  = StStall;
               rfc_d    = FW'(T_RFC - 1);
               pend_clr = 1'b1;
            end else if (wr_req && (!rd_req || !last_wr_q)) begin
               // Ties go to whichever side was not served last; write after reset.
               state_d   = StWack;
               addr_d    = wr_addr;
               wdata_d   = wr_data;
               wr_ack_d  = 1'b1;
               last_wr_d = 1'b1;
            end else if (rd_req) begin
               state_d   = StRburst;
               addr_d    = rd_addr;
               beat_d    = rd_len;
               rd_ack_d  = 1'b1;
               last_wr_d = 1'b0;
            end
         end
         StWack: begin
            ram_we  = 1'b1;
            state_d = StIdle;
         end
         StRburst: begin
            issue = 1'b1;
            if (beat_q == '0) begin
               state_d = StIdle;
            end else begin
               beat_d = beat_q - LEN_W'(1);
               addr_d = addr_q + AWIDTH'(1);
            end
         end
         StStall: begin
            if (rfc_q == '0) begin
               state_d = StIdle;
            end else begin
               rfc_d = rfc_q - FW'(1);
            end
         end
         default: state_d = StInit;
      endcase

      // A fresh expiry in the same cycle as a clear keeps the flag set.
      pend_d = pend_set | (pend_q & ~pend_clr);
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q   <= StInit;
         init_q    <= IW'(T_PWR_UP);
         ri_q      <= RW'(T_RI);
         rfc_q     <= '0;
         beat_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         pend_q    <= 1'b0;
         last_wr_q <= 1'b0;
         rd_ack    <= 1'b0;
         wr_ack    <= 1'b0;
         rd_rdy    <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_q    <= init_d;
         ri_q      <= ri_d;
         rfc_q     <= rfc_d;
         beat_q    <= beat_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         pend_q    <= pend_d;
         last_wr_q <= last_wr_d;
         rd_ack    <= rd_ack_d;
         wr_ack    <= wr_ack_d;
         rd_rdy    <= issue;
      end
   end

   bram_sp #(
      .DWIDTH     (DWIDTH),
      .DEPTH_BITS (DEPTH_BITS)
   ) u_ram (
      .clk    (clk),
      .sreset (sreset),
      .we     (ram_we),
      .re     (issue),
      .addr   (addr_q[DEPTH_BITS-1:0]),
      .wdata  (wdata_q),
      .rdata  (rd_data)
   );

endmodule

// File: doc/bram_responder.md
Name: bram_responder

Overview:
- Responder for the rd/wr request-ack memory interface that the SDRAM controller exposes. It is a drop-in, pin-compatible stand-in for the controller on the requester side.
- Backed by on-chip block RAM instead of external SDRAM.
- Emulates power-up delay and periodic refresh stalls, so requesters such as memory testers and DMA engines can be exercised in simulation and on boards without SDRAM.
- Sits between the requester and nothing else; it has no external pins.

Parameters:
- AWIDTH, 20, request address width (words).
- DWIDTH, 16, data word width.
- DEPTH_BITS, 10, RAM depth is 2**DEPTH_BITS words; only the low DEPTH_BITS of each address are used.
- T_PWR_UP, 3, cycles held in INIT after reset before any request is accepted.
- T_RI, 32, refresh interval in cycles; 0 disables refresh emulation.
- T_RFC, 4, stall length per refresh, in cycles (≥1).

Ports:
- clk  in  1  clock
- sreset  in  1  synchronous reset, active-high
- rd_addr  in  AWIDTH  burst start address
- rd_len  in  4  burst length minus one
- rd_req  in  1  read request, held until rd_ack
- rd_ack  out  1  one-cycle accept pulse
- rd_data  out  DWIDTH  read beat data
- rd_rdy  out  1  rd_data valid this cycle
- wr_addr  in  AWIDTH  write address
- wr_data  in  DWIDTH  write data
- wr_len  in  4  reserved, must be 0, ignored
- wr_req  in  1  write request, held until wr_ack
- wr_ack  out  1  one-cycle accept pulse; write committed at this edge

Behaviour:
- Reset: sreset=1 forces state INIT and reloads the init counter to T_PWR_UP and the refresh counter to T_RI. It also clears the pending-refresh flag, the last-served flag and the burst counter.
- Output reset values: rd_ack=0, wr_ack=0, rd_rdy=0, rd_data=0.
- Reset mid-burst aborts the burst: no further rd_rdy is produced. RAM contents are retained.
- All outputs are registered.
- States: INIT, IDLE, WACK, RBURST, STALL.
- INIT: ignore requests; after T_PWR_UP cycles go to IDLE.
- Refresh counter: decrements every cycle outside INIT. At 0 it sets refresh_pending and reloads T_RI. It never interrupts WACK or RBURST.
- IDLE priority is refresh_pending > request.
  - refresh_pending: go to STALL for T_RFC cycles, clear pending, return to IDLE.
  - Else if exactly one of rd_req/wr_req is high, serve it.
  - If both are high, serve the one not served last (round-robin via the last_served flag). After reset, write wins.
- Write, IDLE at cycle N:
  - Capture wr_addr/wr_data; RAM written at edge N+1.
  - wr_ack=1 during N+1 (state WACK).
  - Return to IDLE at N+2, when the requester has already dropped wr_req.
  - Minimum 2 cycles per write.
- Read, IDLE at cycle N:
  - Latch rd_addr and beats=rd_len+1.
  - rd_ack=1 during N+1 (state RBURST); RAM read of addr+0 issued in N+1.
  - One address issued per cycle; rd_rdy is high for rd_len+1 consecutive cycles N+2 … N+2+rd_len with words addr+0 … addr+rd_len.
  - The state returns to IDLE after the last issue, so a new request can be seen at N+2+rd_len; its ack comes at N+3+rd_len.
- Requests are never accepted in an ack cycle: state is WACK or RBURST there.
- Address arithmetic: burst increment is modulo 2**AWIDTH. RAM index is addr[DEPTH_BITS-1:0], so addresses alias every 2**DEPTH_BITS words and a burst crossing the top wraps to index 0.
- Read during a same-address write cannot occur, because operations are serialized.
- rd_data holds its last value when rd_rdy=0; requesters must use it only when rd_rdy=1.
- T_RI=0: refresh counter disabled; STALL is never entered.
- A request dropped before ack (protocol violation): any not-yet-acked request is ignored. If it was selected in IDLE, it still completes.

Decomposition:
- Shared package mem_if_pkg:
  - state enum for this block;
  - burst-length width constant (4);
  - default AWIDTH/DWIDTH constants shared with the SDRAM controller.
- One sub-module, bram_sp: single-port synchronous RAM with 1-cycle read latency, parameterized DWIDTH/DEPTH_BITS, with write enable and no reset of contents.
- FSM, counters and arbitration live in bram_responder.

Test Plan:
1. Power-up: sreset 1 cycle, rd_req held from cycle 0 -> no rd_ack before T_PWR_UP+1 cycles after reset release; all outputs 0 during INIT.
2. Write/read single: write 0xBEEF @0x00005, then read rd_len=0 @0x00005 -> wr_ack one cycle after req seen; rd_ack then exactly one rd_rdy, one cycle later, with data 0xBEEF.
3. Burst with wrap: write 0x1000+i to indices 1016…1023 and 0…7, then read rd_len=15 @0x003F8 -> 16 contiguous rd_rdy with 0x1000…0x100F in order; also read @0x403F8 -> identical data (aliasing).
4. Arbitration: rd_req and wr_req asserted in the same cycle, twice back-to-back after reset -> first wr_ack, then rd_ack, then wr_ack; no double ack.
5. Refresh: T_RI=32, T_RFC=4, continuous rd_len=15 bursts -> no burst is split; each counter expiry produces a 4-cycle gap with no ack starting at the next IDLE.
6. Reset mid-burst: sreset asserted on the 5th rd_rdy of a rd_len=15 burst -> rd_rdy=0 from the next cycle on; a subsequent read after INIT returns the previously written data.
